blk_b63b67: RTL and testbench

//   Parametrised synchronous up/down counter. Next generation of the team's fixed 7-bit up/down counter.

---
 rtl/blk_b63b67_pkg.sv | 16 +
 rtl/blk_b63b67_celula.sv | 29 ++
 rtl/blk_b63b67.sv | 85 ++++++++
 tb/tb_blk_b63b67.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/blk_b63b67_pkg.sv
// Shared constants and helpers for the parametrised up/down counter family.
package blk_b63b67_pkg;

    typedef enum logic {
        CNT_DOWN = 1'b0,
        CNT_UP   = 1'b1
    } cnt_dir_e;

    localparam int unsigned CNT_WRAP = 0;
    localparam int unsigned CNT_SAT  = 1;

    function automatic int unsigned cnt_maxval(input int unsigned w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/blk_b63b67_celula.sv
// One counter bit: T-flop with synchronous clear, preset, parallel load and enable.
module contador_celula_t #(
    parameter logic PRST_VAL = 1'b1
) (
    input  logic clk,
    input  logic clr,
    input  logic prst,
    input  logic load,
    input  logic d,
    input  logic t,
    input  logic enable,
    output logic q,
    output logic q_bar
);

    always_ff @(posedge clk) begin
        if (clr)
            q <= 1'b0;
        else if (prst)
            q <= PRST_VAL;
        else if (load)
            q <= d;
        else if (enable && t)
            q <= ~q;
    end

    always_comb q_bar = ~q;

endmodule

// File: rtl/blk_b63b67.sv
// Parametrised synchronous up/down counter: T-cell chain plus boundary override,
// load clamp, terminal count and wrap pulse.
module blk_b63b67
    import blk_b63b67_pkg::*;
#(
    parameter int unsigned WIDTH    = 7,
    parameter int unsigned MAX      = cnt_maxval(WIDTH),
    parameter int unsigned SATURATE = CNT_WRAP
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             prst,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam bit               SAT   = (SATURATE == CNT_SAT);

    logic [WIDTH-1:0] q_bar;
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] cell_d;
    logic             at_bound;
    logic             cell_load;

    always_comb begin
        at_bound = (up_down == CNT_UP) ? (q == MAX_V) : (q == '0);
        tc       = enable & at_bound;
    end

    always_comb begin
        up_t    = '0;
        dn_t    = '0;
        up_t[0] = 1'b1;
        dn_t[0] = 1'b1;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            up_t[i] = up_t[i-1] & q[i-1];
            dn_t[i] = dn_t[i-1] & q_bar[i-1];
        end
        t = (up_down == CNT_UP) ? up_t : dn_t;
    end

    // At a boundary the toggle chain would step past 0..MAX, so the next value
    // is forced through the cells' load path instead; user load wins and is clamped.
    always_comb begin
        cell_load = load | tc;
        if (load)
            cell_d = (d > MAX_V) ? MAX_V : d;
        else if (up_down == CNT_UP)
            cell_d = SAT ? MAX_V : '0;
        else
            cell_d = SAT ? '0 : MAX_V;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        contador_celula_t #(
            .PRST_VAL(MAX_V[i])
        ) u_cell (
            .clk   (clk),
            .clr   (clr),
            .prst  (prst),
            .load  (cell_load),
            .d     (cell_d[i]),
            .t     (t[i]),
            .enable(enable),
            .q     (q[i]),
            .q_bar (q_bar[i])
        );
    end

    always_ff @(posedge clk) begin
        if (clr || prst || load)
            wrap <= 1'b0;
        else
            wrap <= !SAT && tc;
    end

endmodule

// File: tb/tb_blk_b63b67.sv
// Bench for the up/down counter: three configurations driven from shared controls.
module tb_blk_b63b67;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr, prst, enable, up_down, load;
    logic [6:0] d;

    logic [6:0] q_a;
    logic [3:0] q_b, q_c;
    logic       tc_a, tc_b, tc_c, wrap_a, wrap_b, wrap_c;

    blk_b63b67 #(.WIDTH(7), .MAX(127), .SATURATE(0)) dut_a (
        .clk(clk), .clr(clr), .prst(prst), .enable(enable), .up_down(up_down),
        .load(load), .d(d), .q(q_a), .tc(tc_a), .wrap(wrap_a));

    blk_b63b67 #(.WIDTH(4), .MAX(9), .SATURATE(0)) dut_b (
        .clk(clk), .clr(clr), .prst(prst), .enable(enable), .up_down(up_down),
        .load(load), .d(d[3:0]), .q(q_b), .tc(tc_b), .wrap(wrap_b));

    blk_b63b67 #(.WIDTH(4), .MAX(9), .SATURATE(1)) dut_c (
        .clk(clk), .clr(clr), .prst(prst), .enable(enable), .up_down(up_down),
        .load(load), .d(d[3:0]), .q(q_c), .tc(tc_c), .wrap(wrap_c));

    int n_vec = 0;
    int n_err = 0;

    int m_q   [3];
    bit m_w   [3];
    int m_max [3] = '{127, 9, 9};
    bit m_sat [3] = '{1'b0, 1'b0, 1'b1};

    typedef struct {
        bit       clr, prst, load, en, ud;
        bit [3:0] d;
        int       qb;
        bit       wb;
        int       qc;
        bit       wc;
    } vec_t;

    vec_t tbl [24];

    function automatic int dut_q(input int k);
        case (k)
            0:       return int'(q_a);
            1:       return int'(q_b);
            default: return int'(q_c);
        endcase
    endfunction

    function automatic int dut_tc(input int k);
        case (k)
            0:       return int'(tc_a);
            1:       return int'(tc_b);
            default: return int'(tc_c);
        endcase
    endfunction

    function automatic int dut_w(input int k);
        case (k)
            0:       return int'(wrap_a);
            1:       return int'(wrap_b);
            default: return int'(wrap_c);
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit c, input bit p, input bit l, input bit e,
                         input bit u, input int dd);
        clr = c; prst = p; load = l; enable = e; up_down = u; d = 7'(dd);
    endtask

    // Reference: the counter as a number on 0..MAX with plain integer rules.
    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            int dk;
            dk = (k == 0) ? int'(d) : int'(d[3:0]);
            m_w[k] = 1'b0;
            if (clr)
                m_q[k] = 0;
            else if (prst)
                m_q[k] = m_max[k];
            else if (load)
                m_q[k] = (dk > m_max[k]) ? m_max[k] : dk;
            else if (enable) begin
                if (up_down) begin
                    if (m_q[k] < m_max[k]) m_q[k] = m_q[k] + 1;
                    else begin m_q[k] = m_sat[k] ? m_max[k] : 0; m_w[k] = !m_sat[k]; end
                end else begin
                    if (m_q[k] > 0) m_q[k] = m_q[k] - 1;
                    else begin m_q[k] = m_sat[k] ? 0 : m_max[k]; m_w[k] = !m_sat[k]; end
                end
            end
        end
    endtask

    // Inputs are already driven; check tc, take one edge, check q and wrap.
    task automatic cycle(input string tag);
        #1;
        for (int k = 0; k < 3; k++)
            check($sformatf("%s tc[%0d]", tag, k), dut_tc(k),
                  int'(enable && (up_down ? (m_q[k] == m_max[k]) : (m_q[k] == 0))));
        @(posedge clk);
        model_edge();
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s q[%0d]", tag, k), dut_q(k), m_q[k]);
            check($sformatf("%s wrap[%0d]", tag, k), dut_w(k), int'(m_w[k]));
        end
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            m_q[k] = 0;
            m_w[k] = 1'b0;
            check($sformatf("reset q[%0d]", k), dut_q(k), 0);
            check($sformatf("reset wrap[%0d]", k), dut_w(k), 0);
        end
        drive(0, 0, 0, 1, 0, 0);
        #1;
        check("reset tc_b down", int'(tc_b), 1);

        // clr,prst,load,en,ud,d, qb,wb, qc,wc
        tbl[0]  = '{1,0,0,0,0, 0, 0,0, 0,0};
        tbl[1]  = '{0,0,1,0,0, 7, 7,0, 7,0};
        tbl[2]  = '{0,0,0,1,1, 0, 8,0, 8,0};
        tbl[3]  = '{0,0,0,1,1, 0, 9,0, 9,0};
        tbl[4]  = '{0,0,0,1,1, 0, 0,1, 9,0};
        tbl[5]  = '{0,0,0,1,1, 0, 1,0, 9,0};
        tbl[6]  = '{1,0,0,0,0, 0, 0,0, 0,0};
        tbl[7]  = '{0,0,0,1,0, 0, 9,1, 0,0};
        tbl[8]  = '{0,0,0,1,0, 0, 8,0, 0,0};
        tbl[9]  = '{0,0,1,1,1,12, 9,0, 9,0};
        tbl[10] = '{0,0,0,1,1, 0, 0,1, 9,0};
        tbl[11] = '{0,1,1,1,1, 3, 9,0, 9,0};
        tbl[12] = '{1,1,1,1,1, 3, 0,0, 0,0};
        tbl[13] = '{0,0,1,0,0, 3, 3,0, 3,0};
        tbl[14] = '{0,0,0,1,1, 0, 4,0, 4,0};
        tbl[15] = '{0,0,0,1,1, 0, 5,0, 5,0};
        tbl[16] = '{0,0,0,1,0, 0, 4,0, 4,0};
        tbl[17] = '{0,0,0,1,0, 0, 3,0, 3,0};
        tbl[18] = '{0,0,0,1,0, 0, 2,0, 2,0};
        tbl[19] = '{0,0,0,0,0, 0, 2,0, 2,0};
        tbl[20] = '{0,0,0,0,1, 0, 2,0, 2,0};
        tbl[21] = '{0,0,0,0,0, 0, 2,0, 2,0};
        tbl[22] = '{0,1,0,1,1, 0, 9,0, 9,0};
        tbl[23] = '{1,0,0,1,1, 0, 0,0, 0,0};

        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].clr, tbl[i].prst, tbl[i].load, tbl[i].en, tbl[i].ud, int'(tbl[i].d));
            cycle($sformatf("tbl%0d", i));
            check($sformatf("tbl%0d qb", i), int'(q_b), tbl[i].qb);
            check($sformatf("tbl%0d wb", i), int'(wrap_b), int'(tbl[i].wb));
            check($sformatf("tbl%0d qc", i), int'(q_c), tbl[i].qc);
            check($sformatf("tbl%0d wc", i), int'(wrap_c), int'(tbl[i].wc));
        end

        // Full 7-bit up run across the 127 -> 0 wrap.
        drive(1, 0, 0, 0, 0, 0);
        cycle("up7 clr");
        for (int i = 1; i <= 130; i++) begin
            drive(0, 0, 0, 1, 1, 0);
            #1;
            check($sformatf("up7 tc e%0d", i), int'(tc_a), int'(i - 1 == 127));
            cycle($sformatf("up7 e%0d", i));
            check($sformatf("up7 q e%0d", i), int'(q_a), i % 128);
            check($sformatf("up7 wrap e%0d", i), int'(wrap_a), int'(i == 128));
        end

        // Mod-10 down run from zero.
        drive(1, 0, 0, 0, 0, 0);
        cycle("dn10 clr");
        for (int i = 1; i <= 21; i++) begin
            drive(0, 0, 0, 1, 0, 0);
            cycle($sformatf("dn10 e%0d", i));
            check($sformatf("dn10 q e%0d", i), int'(q_b), (10 - (i % 10)) % 10);
            check($sformatf("dn10 wrap e%0d", i), int'(wrap_b), int'(i % 10 == 1));
        end

        // Random controls against the reference model.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(31) == 0), ($urandom_range(31) == 0),
                  ($urandom_range(7) == 0), ($urandom_range(3) != 0),
                  1'($urandom_range(1)), int'($urandom_range(127)));
            cycle($sformatf("rnd%0d", i));
            check($sformatf("rnd%0d qb range", i), int'(q_b <= 4'd9), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule
